// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: drives PC/IF-ID enables against a variable-latency imem.
// Optional performance counters are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_ctrl #(
  parameter int unsigned MAX_WAIT = 15
`ifdef IF_FETCH_PERF_EN
  ,
  parameter int unsigned CNT_W    = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic             pcsrc,
  input  logic             load_use_stall,
  output logic             pc_sel,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_flush,
  output logic             fetch_err
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_fetched,
  output logic [CNT_W-1:0] perf_bubbles,
  output logic [CNT_W-1:0] perf_killed
`endif
);

  // state | meaning
  // IDLE  | out of reset, no request issued
  // FETCH | request outstanding at the current PC
  // KILL  | stale request in flight after a redirect; its data is dropped
  typedef enum logic [1:0] {IDLE, FETCH, KILL} state_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    pc_sel      = 1'b0;
    PCWrite     = 1'b0;
    IF_ID_Write = 1'b0;
    IF_ID_flush = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (pcsrc) begin
          // redirect squashes the ID instruction even under a load-use stall
          PCWrite     = 1'b1;
          pc_sel      = 1'b1;
          IF_ID_Write = 1'b1;
          IF_ID_flush = 1'b1;
          if (!imem_ready) state_d = KILL;
        end else if (imem_ready) begin
          if (!load_use_stall) begin
            PCWrite     = 1'b1;
            IF_ID_Write = 1'b1;
          end
        end else if (!load_use_stall) begin
          IF_ID_Write = 1'b1;
          IF_ID_flush = 1'b1;
        end
      end
      KILL: begin
        imem_req = 1'b1;
        if (pcsrc) begin
          PCWrite     = 1'b1;
          pc_sel      = 1'b1;
          IF_ID_Write = 1'b1;
          IF_ID_flush = 1'b1;
        end else if (!load_use_stall) begin
          IF_ID_Write = 1'b1;
          IF_ID_flush = 1'b1;
        end
        if (imem_ready) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait counter saturates; fetch_err is sticky and the FSM keeps waiting.
  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE || imem_ready) begin
      wait_d = '0;
    end else if (imem_req && wait_q != MAX_W) begin
      wait_d = wait_q + 8'd1;
    end
    err_d = err_q | (wait_d == MAX_W);
  end

  assign fetch_err = err_q;

`ifdef IF_FETCH_PERF_EN
  logic fetched_ev, bubble_ev, killed_ev;

  assign fetched_ev = (state_q == FETCH) & imem_ready & ~load_use_stall & ~pcsrc;
  assign bubble_ev  = IF_ID_Write & IF_ID_flush;
  assign killed_ev  = imem_ready & ((state_q == KILL) | ((state_q == FETCH) & pcsrc));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
      perf_killed  <= '0;
    end else begin
      if (fetched_ev) perf_fetched <= perf_fetched + 1'b1;
      if (bubble_ev)  perf_bubbles <= perf_bubbles + 1'b1;
      if (killed_ev)  perf_killed  <= perf_killed + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: output-vector scoreboard plus a PC/fetch-address model.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_ready = 1'b0;
  logic        pcsrc = 1'b0;
  logic        load_use_stall = 1'b0;
  logic        imem_req, pc_sel, PCWrite, IF_ID_Write, IF_ID_flush, fetch_err;
  logic [31:0] br_target = 32'h0;
  logic [31:0] pc_q;
  logic        req_prev, rdy_prev;

  logic [5:0]  exp_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0;
  int          errors = 0;

  // {imem_req, PCWrite, pc_sel, IF_ID_Write, IF_ID_flush, fetch_err}
  localparam logic [5:0] E_IDLE = 6'b000000;
  localparam logic [5:0] E_RD   = 6'b110100;
  localparam logic [5:0] E_BUB  = 6'b100110;
  localparam logic [5:0] E_RED  = 6'b111110;
  localparam logic [5:0] E_HOLD = 6'b100000;
  localparam logic [5:0] ERR    = 6'b000001;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.MAX_WAIT(15)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_ready     (imem_ready),
    .pcsrc          (pcsrc),
    .load_use_stall (load_use_stall),
    .pc_sel         (pc_sel),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_flush    (IF_ID_flush),
    .fetch_err      (fetch_err)
  );

  // PC register of the IF stage and request-start tracking
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= 32'h0;
      req_prev <= 1'b0;
      rdy_prev <= 1'b0;
    end else begin
      if (PCWrite) pc_q <= pc_sel ? br_target : pc_q + 32'd4;
      req_prev <= imem_req;
      rdy_prev <= imem_ready;
    end
  end

  always @(negedge clk) begin : monitor
    logic [5:0]  e, obs;
    logic [31:0] a;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      obs = {imem_req, PCWrite, pc_sel, IF_ID_Write, IF_ID_flush, fetch_err};
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL outputs t=%0t: got %b expected %b (req,pcw,sel,ifw,flush,err)", $time, obs, e);
      end
    end
    if (imem_req && (!req_prev || rdy_prev)) begin
      a = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      assert (pc_q === a) else begin
        errors++;
        $error("FAIL fetch_addr t=%0t: got %h expected %h", $time, pc_q, a);
      end
    end
  end

  task automatic step(input logic r, input logic rdy, input logic pcs, input logic stl,
                      input logic [31:0] tgt, input logic [5:0] e);
    @(posedge clk);
    #1;
    rst            = r;
    imem_ready     = rdy;
    pcsrc          = pcs;
    load_use_stall = stl;
    br_target      = tgt;
    exp_q.push_back(e);
  endtask

  initial begin
    // reset, then release; ready while IDLE is ignored
    step(0, 0, 0, 0, 0, E_IDLE);
    step(0, 1, 0, 0, 0, E_IDLE);
    step(1, 1, 0, 0, 0, E_IDLE);

    // back-to-back single-cycle fetches
    addr_q.push_back(32'h0);  addr_q.push_back(32'h4);
    addr_q.push_back(32'h8);  addr_q.push_back(32'hC);
    repeat (4) step(1, 1, 0, 0, 0, E_RD);

    // 3-cycle memory latency: two bubbles then a write
    addr_q.push_back(32'h10); addr_q.push_back(32'h14);
    repeat (2) begin
      step(1, 0, 0, 0, 0, E_BUB);
      step(1, 0, 0, 0, 0, E_BUB);
      step(1, 1, 0, 0, 0, E_RD);
    end

    // redirect while outstanding -> KILL; stall hold, second redirect wins
    addr_q.push_back(32'h18); addr_q.push_back(32'h40);
    step(1, 0, 0, 0, 0,      E_BUB);
    step(1, 0, 0, 0, 0,      E_BUB);
    step(1, 0, 1, 0, 32'h30, E_RED);
    step(1, 0, 0, 1, 0,      E_HOLD);
    step(1, 0, 1, 0, 32'h40, E_RED);
    step(1, 1, 0, 0, 0,      E_BUB);
    step(1, 1, 0, 0, 0,      E_RD);

    // redirect together with ready: stays FETCH (next ready writes, no bubble)
    addr_q.push_back(32'h44); addr_q.push_back(32'h80);
    step(1, 1, 1, 0, 32'h80, E_RED);
    step(1, 1, 0, 0, 0,      E_RD);

    // load-use stall with ready: drop and refetch same PC
    addr_q.push_back(32'h84); addr_q.push_back(32'h84); addr_q.push_back(32'h84);
    step(1, 1, 0, 1, 0, E_HOLD);
    step(1, 1, 0, 1, 0, E_HOLD);
    step(1, 1, 0, 0, 0, E_RD);

    // stall while waiting
    addr_q.push_back(32'h88);
    step(1, 0, 0, 1, 0, E_HOLD);
    step(1, 1, 0, 0, 0, E_RD);

    // timeout: fetch_err after 15 wait cycles, sticky past ready
    addr_q.push_back(32'h8C);
    repeat (15) step(1, 0, 0, 0, 0, E_BUB);
    step(1, 0, 0, 0, 0, E_BUB | ERR);
    step(1, 1, 0, 0, 0, E_RD | ERR);
    addr_q.push_back(32'h90);
    step(1, 0, 0, 0, 0, E_BUB | ERR);

    // async reset mid-wait clears everything within the cycle
    step(0, 0, 0, 0, 0, E_IDLE);
    step(0, 1, 0, 0, 0, E_IDLE);
    step(1, 1, 0, 0, 0, E_IDLE);
    addr_q.push_back(32'h0);  addr_q.push_back(32'h4);
    step(1, 1, 0, 0, 0, E_RD);
    step(1, 1, 0, 0, 0, E_RD);

    @(negedge clk);
    #1;
    checks++;
    assert (addr_q.size() == 0 && exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: addr_q=%0d exp_q=%0d expected 0 0", addr_q.size(), exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Sequences the instruction-fetch stage against a variable-latency instruction memory using a req/ready handshake.
- Generates PCWrite, IF_ID_Write and IF_ID_flush for the IF stage and the PC-source select; absorbs branch redirects and load-use stalls.
- Sits between the hazard unit/EX branch resolution and the IF stage; it replaces direct hazard-unit drive of the IF control pins.

Parameters:
- MAX_WAIT, 15: cycles a single request may stay outstanding before fetch_err sets (1..255).
- CNT_W, 32: width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request. Memory captures the PC on the first cycle of each request, i.e. the cycle imem_req rises or the cycle after an imem_ready.
- imem_ready  in  1  instruction valid this cycle for the outstanding request.
- pcsrc  in  1  EX-stage taken branch/jump (pulse); br_target valid the same cycle.
- load_use_stall  in  1  hazard unit: hold PC and IF/ID.
- pc_sel  out  1  1 = PC_next takes br_target, 0 = PC+4.
- PCWrite  out  1  PC register load enable.
- IF_ID_Write  out  1  IF/ID register load enable.
- IF_ID_flush  out  1  IF/ID loads a bubble (NOP) when written.
- fetch_err  out  1  sticky: a request exceeded MAX_WAIT cycles.

Behaviour:
- States: IDLE, FETCH, KILL. Reset (rst=0, async) forces:
  - state IDLE, wait counter 0, fetch_err 0.
  - imem_req, pc_sel, PCWrite, IF_ID_Write and IF_ID_flush all 0.
- IDLE: all outputs 0; goes to FETCH on the next clk after reset release.
- FETCH: imem_req=1. Priority is pcsrc, then imem_ready, then waiting.
  - pcsrc=1: PCWrite=1, pc_sel=1, IF_ID_Write=1, IF_ID_flush=1. This holds even with load_use_stall=1, because a redirect squashes the ID instruction. With imem_ready=1 the returned instruction is discarded and the state stays FETCH. With imem_ready=0 the state goes to KILL.
  - imem_ready=1, stall=0: PCWrite=1, pc_sel=0, IF_ID_Write=1, IF_ID_flush=0. The instruction enters IF/ID and the next request starts the following cycle.
  - imem_ready=1, stall=1: PCWrite=0, IF_ID_Write=0. The instruction is dropped and the same PC is refetched.
  - Waiting (imem_ready=0), stall=0: PCWrite=0, IF_ID_Write=1, IF_ID_flush=1, inserting a bubble.
  - Waiting, stall=1: PCWrite=0, IF_ID_Write=0.
- KILL: the stale request is still in flight; imem_req stays 1 until imem_ready.
  - Each cycle: bubble (IF_ID_Write=1, flush=1) unless stall=1, then hold (IF_ID_Write=0).
  - A further pcsrc in KILL: PCWrite=1, pc_sel=1, state stays KILL (the newest target wins).
  - imem_ready: data discarded, no PCWrite unless pcsrc, next state FETCH (new request at the redirected PC).
- pc_sel=0 whenever pcsrc=0. PCWrite is never 1 without imem_ready or pcsrc in the same cycle.
- Wait counter:
  - Clears on each cycle with imem_ready=1, and while in IDLE.
  - Otherwise increments each cycle imem_req=1, saturating at MAX_WAIT.
  - Reaching MAX_WAIT sets fetch_err, which is sticky until reset. The FSM keeps waiting; there is no auto-abort.
- Reset mid-request: the FSM returns to IDLE immediately. Any imem_ready in IDLE is ignored.
- All outputs are Moore/Mealy combinational from state plus same-cycle inputs; no added latency on pcsrc.

Optional Feature:
- Macro IF_FETCH_PERF_EN.
- When defined, adds three CNT_W-bit output counters, each reset to 0 and wrapping at 2^CNT_W:
  - perf_fetched: increments on FETCH & imem_ready & !stall & !pcsrc.
  - perf_bubbles: increments on any cycle with IF_ID_Write & IF_ID_flush.
  - perf_killed: increments on each imem_ready in KILL plus each imem_ready discarded on a FETCH pcsrc.
- When undefined, these ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Reset release, imem_ready held 1, no hazards → IDLE 1 cycle, then PCWrite=1, IF_ID_Write=1 every cycle; PC sequence 0,4,8,12.
- imem_ready arrives 3 cycles after each request → per instruction: 2 bubble cycles (IF_ID_Write=1, flush=1) then 1 write cycle; PCWrite=1 only on the ready cycle.
- pcsrc pulse with br_target=0x40 while a request is 2 cycles outstanding → same cycle PCWrite=1, pc_sel=1, flush=1; state KILL; the next imem_ready is discarded; the following fetch is at 0x40.
- pcsrc and imem_ready in the same FETCH cycle → instruction discarded, PC=br_target, state stays FETCH, no KILL entry.
- load_use_stall=1 for 2 cycles with imem_ready=1 → PCWrite=0, IF_ID_Write=0 both cycles; PC unchanged; instruction refetched after the stall drops.
- imem_ready withheld 16 cycles with MAX_WAIT=15 → fetch_err=1 after the 15th wait cycle and stays 1 after ready returns; an async rst=0 mid-wait clears it and all outputs within the same cycle.
